clock_div_multi: RTL
====================

Name: clock_div_multi

Overview:
Parametrised multi-channel clock divider. It generates NUM_CH derived clocks from sys_clk, plus a one-cycle tick strobe per channel. Each channel has a runtime-reloadable integer divisor, applied glitch-free at a period boundary. A global sync restarts all channels in phase. It replaces the fixed ÷4 pixel-clock generator in the VGA path and provides pixel clocks and enables for several video modes.

Parameters:
NUM_CH, 2, number of independent output channels (1..8)
DIV_W, 8, divisor width in bits (2..16)
DEFAULT_DIV, 4, divisor loaded into every channel at reset (must be >= 2)

Ports:
sys_clk  in  1  system clock (100 MHz)
sys_rst_n  in  1  synchronous, active-high reset (port name kept as in the codebase; asserted = 1)
sync  in  1  one-cycle pulse; restarts all active channels at phase 0
div_in  in  NUM_CH*DIV_W  packed divisors; channel k uses bits [k*DIV_W +: DIV_W]
div_load  in  NUM_CH  per-channel load strobe for div_in
div_ack  out  NUM_CH  one-cycle pulse when a loaded divisor takes effect
clk_out  out  NUM_CH  divided clock per channel (registered)
tick  out  NUM_CH  one-cycle strobe on each clk_out rising cycle (registered)

Behaviour:
- All logic is on the posedge of sys_clk. Every output is registered.
- Reset (sys_rst_n=1):
  - active divisor = DEFAULT_DIV; pending register cleared.
  - cnt = DEFAULT_DIV-1, so the next count is 0.
  - clk_out=0, tick=0, div_ack=0.
  - Reset overrides sync and div_load in the same cycle.
- First edge after reset release: cnt=0, clk_out=1, tick=1.
- Per-channel counter, divisor D (D >= 2):
  - cnt runs 0..D-1 and wraps to 0.
  - HI = D - floor(D/2).
  - clk_out=1 while cnt < HI, else 0. Odd D gives one extra high cycle.
  - tick=1 only in cycles where cnt==0.
- Examples:
  - D=4: high,high,low,low (25 MHz).
  - D=5: 3 high, 2 low.
  - D=2: alternates high/low.
- Reload:
  - div_load[k] captures div_in slice k into pending[k] and sets pend_v[k].
  - A later load before the wrap overwrites pending (last wins).
  - pending is applied on the wrap edge (cnt D-1 -> 0). That edge's new period uses the new D, and div_ack[k]=1 in that same cycle (coincident with tick).
  - A load sampled on the wrap edge itself is applied at that wrap.
  - The current period is never truncated or stretched.
- Invalid divisor (value 0 or 1):
  - When applied, the channel enters IDLE: clk_out=0, tick=0, cnt frozen. div_ack still pulses.
  - From IDLE, a valid load is applied on the next edge with no wrap wait: cnt=0, clk_out=1, tick=1, div_ack=1.
- Per-channel states: RUN, IDLE.
  - RUN -> IDLE: invalid divisor applied.
  - IDLE -> RUN: valid divisor applied.
  - Reset -> RUN.
- sync:
  - On the next edge, every RUN channel goes to cnt=0, clk_out=1, tick=1.
  - Any pending divisors are applied at that edge and div_ack pulses for them.
  - IDLE channels stay IDLE unless a valid pending divisor is applied.
  - sync together with div_load: the new div_in value is used immediately.
- Channels are fully independent apart from sync and reset.
- Width rule: the counter is DIV_W bits; D = 2^DIV_W - 1 is the maximum supported value.

Decomposition:
- Package clock_div_pkg holds:
  - DIV_W default
  - MIN_DIV=2
  - typedef div_t (logic [DIV_W-1:0])
  - enum chan_state_t {RUN, IDLE}
- Sub-module clock_div_chan holds one channel (counter, pending register, state, outputs). The top instantiates it NUM_CH times in a generate loop and fans out sync and reset.

Test Plan:
1. Reset, then run 12 cycles, NUM_CH=2, DEFAULT_DIV=4 -> both clk_out show 1100 repeated, tick every 4th cycle starting the first cycle after reset, div_ack=0.
2. Ch0: load 5 at cnt=1 -> current period completes (4 cycles), then pattern 11100, div_ack[0] coincides with the first tick of the new period; ch1 stays unaffected.
3. Ch1: load 0 -> at the next wrap clk_out[1]=0 held, tick[1]=0, ack pulses. Later load 6 -> next cycle clk_out[1]=1, tick=1, then 111000.
4. Ch0 D=4, ch1 D=6, free-running out of phase; pulse sync -> next cycle both tick=1, clk_out=1, then phase-aligned every 12 cycles.
5. Assert reset mid-period with a pending load -> pending discarded, outputs 0 during reset, restart with D=DEFAULT_DIV, no div_ack.
6. Ch0: div_load with value 2 on a wrap edge, same cycle as sync -> applied immediately, ack=1, clk_out alternates 1,0; D=255 (DIV_W=8) -> 128 high, 127 low.

Source files
------------

// File: rtl/clock_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clock_div_pkg;

  // Divisor width used when a block does not override it
  localparam int DIV_W_DEFAULT = 8;

  // Smallest divisor that produces a running clock; anything below idles the channel
  localparam int MIN_DIV = 2;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  typedef enum logic {
    RUN  = 1'b0,
    IDLE = 1'b1
  } chan_state_t;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: period counter, pending divisor, RUN/IDLE state and
// registered clock/tick/ack outputs.
module clock_div_chan
  import clock_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sync_i,
  input  logic [DIV_W-1:0] divIn_i,
  input  logic             load_i,
  output logic             ack_o,
  output logic             clkOut_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_VAL = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEFAULT_DIV);
  // Reset parks the counter on the last count so the first edge wraps to 0
  localparam logic [DIV_W-1:0] CNT_RST = DIV_W'(DEFAULT_DIV - 1);

  logic [DIV_W-1:0] div_q,   div_d;
  logic [DIV_W-1:0] pend_q,  pend_d;
  logic             pendV_q, pendV_d;
  logic [DIV_W-1:0] cnt_q,   cnt_d;
  chan_state_t      state_q, state_d;
  logic             clkOut_q, clkOut_d;
  logic             tick_q,   tick_d;
  logic             ack_q,    ack_d;

  logic [DIV_W-1:0] pendSel;
  logic             pendAvail;
  logic             atWrap;
  logic             applyNow;
  logic [DIV_W-1:0] hiCnt;

  // Next-state: a pending divisor (a same-cycle load wins) is applied at a wrap,
  // on sync, or straight away when idle; otherwise the counter simply advances.
  always_comb begin
    pendSel   = load_i ? divIn_i : pend_q;
    pendAvail = load_i | pendV_q;
    atWrap    = (state_q == RUN) && (cnt_q == div_q - ONE);
    applyNow  = pendAvail && (atWrap || sync_i || (state_q == IDLE));

    div_d   = div_q;
    pend_d  = pendSel;
    pendV_d = pendAvail;
    cnt_d   = cnt_q;
    state_d = state_q;
    ack_d   = 1'b0;

    if (applyNow) begin
      div_d   = pendSel;
      pendV_d = 1'b0;
      ack_d   = 1'b1;
      if (pendSel < MIN_VAL) begin
        state_d = IDLE;
      end else begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end else if (state_q == RUN) begin
      cnt_d = (atWrap || sync_i) ? '0 : cnt_q + ONE;
    end

    hiCnt    = div_d - (div_d >> 1);
    clkOut_d = (state_d == RUN) && (cnt_d < hiCnt);
    tick_d   = (state_d == RUN) && (cnt_d == '0);
  end

  // State and output registers; reset restores the default divisor and drops any pending load
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= DEF_VAL;
      pend_q   <= '0;
      pendV_q  <= 1'b0;
      cnt_q    <= CNT_RST;
      state_q  <= RUN;
      clkOut_q <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      pend_q   <= pend_d;
      pendV_q  <= pendV_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      clkOut_q <= clkOut_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
    end
  end

  assign ack_o    = ack_q;
  assign clkOut_o = clkOut_q;
  assign tick_o   = tick_q;

endmodule

// File: rtl/clock_div_multi.sv
// Multi-channel clock divider: NUM_CH independent channels sharing reset and sync.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    sync,
  input  logic [NUM_CH*DIV_W-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_load,
  output logic [NUM_CH-1:0]       div_ack,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  // The reset port is active-high despite its legacy name
  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : gChan
      clock_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) uChan (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst_n),
        .sync_i   (sync),
        .divIn_i  (div_in[g*DIV_W +: DIV_W]),
        .load_i   (div_load[g]),
        .ack_o    (div_ack[g]),
        .clkOut_o (clk_out[g]),
        .tick_o   (tick[g])
      );
    end
  endgenerate

endmodule
